// File: rtl/clock_pkg.sv
// clock_pkg: shared mode encoding, BCD digit type, terminal values and the 12-hour display mapping
package clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_SET_HH = 2'd1,
    MODE_SET_MM = 2'd2,
    MODE_SET_SS = 2'd3
  } mode_e;

  typedef logic [3:0] bcd_digit_t;

  localparam int SEC_MAX  = 59;
  localparam int MIN_MAX  = 59;
  localparam int HOUR_MAX = 23;

  // Maps a 24-hour BCD value to its 12-hour presentation: 00 -> 12, 13..23 -> 01..11.
  function automatic logic [7:0] bcd_to_12h(input logic [7:0] b);
    int h;
    h = int'(b[7:4]) * 10 + int'(b[3:0]);
    h = (h == 0) ? 12 : (h > 12) ? h - 12 : h;
    return {4'(h / 10), 4'(h % 10)};
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD counter wrapping at MAX, with clear, load and carry-out
module bcd2_counter
  import clock_pkg::*;
#(
  parameter int MAX  = 59,
  parameter int INIT = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_inc,
  input  logic       i_clr,
  input  logic       i_load,
  input  logic [7:0] i_val,
  output logic       o_carry,
  output logic [7:0] o_bcd
);

  if (INIT < 0 || INIT > MAX) begin : g_init_range
    $error("bcd2_counter: INIT %0d outside 0..%0d", INIT, MAX);
  end

  localparam bcd_digit_t MAX_T = 4'(MAX / 10);
  localparam bcd_digit_t MAX_O = 4'(MAX % 10);
  localparam logic [7:0] INIT_BCD = {4'(INIT / 10), 4'(INIT % 10)};

  bcd_digit_t r_t, r_o;
  logic       w_max;

  assign w_max   = (r_t == MAX_T) && (r_o == MAX_O);
  assign o_carry = i_inc && w_max;
  assign o_bcd   = {r_t, r_o};

  // Digit registers: clear beats load beats increment; terminal value wraps to 00.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {r_t, r_o} <= INIT_BCD;
    end else if (i_clr) begin
      {r_t, r_o} <= 8'h00;
    end else if (i_load) begin
      {r_t, r_o} <= i_val;
    end else if (i_inc) begin
      r_t <= w_max ? 4'd0 : (r_o == 4'd9) ? r_t + 4'd1 : r_t;
      r_o <= (w_max || r_o == 4'd9) ? 4'd0 : r_o + 4'd1;
    end
  end

endmodule

// File: rtl/clock_time_core.sv
// clock_time_core: hh:mm:ss BCD timekeeping with button set mode; CLOCK_12H_DISPLAY_EN adds 12-hour display and pm
module clock_time_core
  import clock_pkg::*;
#(
  parameter int INIT_HH = 12,
  parameter int INIT_MM = 0,
  parameter int INIT_SS = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       blink,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [7:0] hh_bcd,
  output logic [7:0] mm_bcd,
  output logic [7:0] ss_bcd,
  output logic [5:0] digit_blank,
  output logic [1:0] mode,
  output logic       day_tick
`ifdef CLOCK_12H_DISPLAY_EN
  ,
  output logic       pm
`endif
);

  mode_e      r_mode, w_mode_nxt;
  logic [5:0] r_blank, w_blank_nxt;
  logic       r_day_tick;
  logic       w_run, w_inc;
  logic       w_ss_inc, w_ss_clr, w_mm_inc, w_hh_inc;
  logic       w_ss_carry, w_mm_carry, w_hh_carry;
  logic [7:0] w_hh;

  // A mode press in the same cycle swallows the increment.
  assign w_run    = (r_mode == MODE_RUN);
  assign w_inc    = btn_inc && !btn_mode;
  assign w_ss_inc = w_run && tick_1hz;
  assign w_ss_clr = (r_mode == MODE_SET_SS) && w_inc;
  assign w_mm_inc = (w_run && w_ss_carry) || ((r_mode == MODE_SET_MM) && w_inc);
  assign w_hh_inc = (w_run && w_mm_carry) || ((r_mode == MODE_SET_HH) && w_inc);

  bcd2_counter #(.MAX(SEC_MAX), .INIT(INIT_SS)) u_ss (
    .clk(clk), .rst(rst), .i_inc(w_ss_inc), .i_clr(w_ss_clr), .i_load(1'b0),
    .i_val(8'h00), .o_carry(w_ss_carry), .o_bcd(ss_bcd)
  );

  bcd2_counter #(.MAX(MIN_MAX), .INIT(INIT_MM)) u_mm (
    .clk(clk), .rst(rst), .i_inc(w_mm_inc), .i_clr(1'b0), .i_load(1'b0),
    .i_val(8'h00), .o_carry(w_mm_carry), .o_bcd(mm_bcd)
  );

  bcd2_counter #(.MAX(HOUR_MAX), .INIT(INIT_HH)) u_hh (
    .clk(clk), .rst(rst), .i_inc(w_hh_inc), .i_clr(1'b0), .i_load(1'b0),
    .i_val(8'h00), .o_carry(w_hh_carry), .o_bcd(w_hh)
  );

  // Next mode, and blanking of the field selected in that mode (suppressed by an accepted increment).
  always_comb begin
    w_mode_nxt  = btn_mode ? mode_e'(r_mode + 2'd1) : r_mode;
    w_blank_nxt = (!blink || w_inc) ? 6'b000000 :
                  (w_mode_nxt == MODE_SET_HH) ? 6'b110000 :
                  (w_mode_nxt == MODE_SET_MM) ? 6'b001100 :
                  (w_mode_nxt == MODE_SET_SS) ? 6'b000011 : 6'b000000;
  end

  // Mode state, blank flags and the midnight pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode     <= MODE_RUN;
      r_blank    <= 6'b000000;
      r_day_tick <= 1'b0;
    end else begin
      r_mode     <= w_mode_nxt;
      r_blank    <= w_blank_nxt;
      r_day_tick <= w_run && w_hh_carry;
    end
  end

  assign mode        = r_mode;
  assign digit_blank = r_blank;
  assign day_tick    = r_day_tick;

`ifdef CLOCK_12H_DISPLAY_EN
  assign hh_bcd = bcd_to_12h(w_hh);
  assign pm     = (w_hh[7:4] == 4'd2) || ((w_hh[7:4] == 4'd1) && (w_hh[3:0] >= 4'd2));
`else
  assign hh_bcd = w_hh;
`endif

endmodule

// File: tb/tb_clock_time_core.sv
// tb_clock_time_core: directed and random stimulus checked against a seconds-of-day reference model
module tb_clock_time_core;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       blink = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [7:0] hh_bcd, mm_bcd, ss_bcd;
  logic [5:0] digit_blank;
  logic [1:0] mode;
  logic       day_tick;
`ifdef CLOCK_12H_DISPLAY_EN
  logic       pm;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  int         t;
  int         md;
  bit         day;
  logic [5:0] blk;

  always #5 clk = ~clk;

  clock_time_core #(.INIT_HH(12), .INIT_MM(0), .INIT_SS(0)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .blink(blink),
    .btn_mode(btn_mode), .btn_inc(btn_inc),
    .hh_bcd(hh_bcd), .mm_bcd(mm_bcd), .ss_bcd(ss_bcd),
    .digit_blank(digit_blank), .mode(mode), .day_tick(day_tick)
`ifdef CLOCK_12H_DISPLAY_EN
    , .pm(pm)
`endif
  );

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic void mreset();
    t   = 12 * 3600;
    md  = 0;
    day = 1'b0;
    blk = 6'd0;
  endfunction

  function automatic void mstep(input bit tk, input bit bm, input bit bi, input bit bl);
    bit ie;
    int h, m, s;
    ie = bi && !bm;
    h  = t / 3600;
    m  = (t / 60) % 60;
    s  = t % 60;
    day = 1'b0;
    if (md == 0 && tk) begin
      t   = (t + 1) % 86400;
      day = (t == 0);
    end else if (ie && md == 1) t = ((h + 1) % 24) * 3600 + m * 60 + s;
    else if (ie && md == 2) t = h * 3600 + ((m + 1) % 60) * 60 + s;
    else if (ie && md == 3) t = h * 3600 + m * 60;
    if (bm) md = (md + 1) % 4;
    blk = (md == 0 || !bl || ie) ? 6'd0 : 6'(6'b000011 << (2 * (3 - md)));
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int h;
    h = t / 3600;
`ifdef CLOCK_12H_DISPLAY_EN
    chk("hh_bcd", hh_bcd, bcd((h == 0) ? 12 : (h > 12) ? h - 12 : h));
    chk("pm", {7'd0, pm}, {7'd0, h >= 12});
`else
    chk("hh_bcd", hh_bcd, bcd(h));
`endif
    chk("mm_bcd", mm_bcd, bcd((t / 60) % 60));
    chk("ss_bcd", ss_bcd, bcd(t % 60));
    chk("mode", {6'd0, mode}, 8'(md));
    chk("digit_blank", {2'd0, digit_blank}, {2'd0, blk});
    chk("day_tick", {7'd0, day_tick}, {7'd0, day});
  endtask

  task automatic step(input bit tk, input bit bm, input bit bi, input bit bl);
    tick_1hz = tk;
    btn_mode = bm;
    btn_inc  = bi;
    blink    = bl;
    @(posedge clk);
    mstep(tk, bm, bi, bl);
    #1;
    tick_1hz = 1'b0;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    check_all();
  endtask

  initial begin
    mreset();
    #22;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    // three seconds from 12:00:00
    repeat (3) step(1, 0, 0, 0);
    chk("ss_after_3_ticks", ss_bcd, 8'h03);
    // walk the set modes to 23:59:00, then run to 23:59:58
    step(0, 1, 0, 0);
    repeat (11) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    repeat (59) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    repeat (58) step(1, 0, 0, 0);
    chk("preload_ss", ss_bcd, 8'h58);
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("midnight_hh", hh_bcd, 8'h00);
    chk("midnight_day_tick", {7'd0, day_tick}, 8'h01);
    step(0, 0, 0, 1);
    chk("day_tick_one_cycle", {7'd0, day_tick}, 8'h00);
    // fresh start at 12:00:00, enter SET_HH with blink high
    @(negedge clk);
    rst = 1'b1;
    mreset();
    @(negedge clk);
    rst = 1'b0;
    step(0, 1, 0, 1);
    chk("set_hh_blank", {2'd0, digit_blank}, 8'h30);
    repeat (13) step(0, 0, 1, 1);
    chk("hh_wrap_13_incs", hh_bcd, 8'h01);
    step(1, 0, 0, 1);
    step(0, 1, 1, 1);
    chk("mode_beats_inc", {6'd0, mode}, 8'h02);
    repeat (59) step(0, 0, 1, 1);
    step(1, 0, 0, 1);
    step(0, 0, 1, 0);
    chk("mm_wrap_no_carry", mm_bcd, 8'h00);
    // asynchronous reset between edges while in SET_MM
    #2;
    rst = 1'b1;
    mreset();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
    // tick and mode press together in RUN
    step(1, 1, 0, 1);
    chk("tick_with_mode_ss", ss_bcd, 8'h01);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    step(0, 1, 0, 1);
    // random traffic
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
